// File: rtl/uart_tx_dma.sv
// uart_tx_dma: fetches 32-bit words from memory and writes their bytes little-endian to a UART data register
module uart_tx_dma #(
  parameter logic [31:0] UART_BASE = 32'h0,
  parameter int          LEN_W     = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             cfg_start,
  input  logic [31:0]      cfg_base,
  input  logic [LEN_W-1:0] cfg_len,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [31:0]      mem_adr,
  output logic             mem_stb,
  input  logic             mem_ack,
  input  logic [31:0]      mem_dat,
  output logic [31:0]      u_adr_o,
  output logic [31:0]      u_dat_o,
  output logic             u_we_o,
  output logic             u_stb_o,
  input  logic             u_ack_i
);
  typedef enum logic [2:0] {IDLE, FETCH, SEND, GAP, FIN} state_t;
  state_t           state;
  logic [31:0]      addr;
  logic [31:0]      word;
  logic [LEN_W-1:0] rem;
  logic [1:0]       byte_idx;
  // Transfer sequencer; every output is a register updated alongside the state
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= IDLE;
      addr     <= '0;
      word     <= '0;
      rem      <= '0;
      byte_idx <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      mem_adr  <= '0;
      mem_stb  <= 1'b0;
      u_adr_o  <= '0;
      u_dat_o  <= '0;
      u_we_o   <= 1'b0;
      u_stb_o  <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: if (cfg_start) begin
          if (cfg_base[1:0] != 2'b00) err <= 1'b1;
          else if (cfg_len == '0) done <= 1'b1;
          else begin
            addr     <= cfg_base;
            rem      <= cfg_len;
            byte_idx <= '0;
            mem_adr  <= cfg_base;
            mem_stb  <= 1'b1;
            busy     <= 1'b1;
            state    <= FETCH;
          end
        end
        FETCH: if (mem_ack) begin
          word     <= mem_dat;
          addr     <= addr + 32'd4;
          byte_idx <= '0;
          mem_stb  <= 1'b0;
          u_stb_o  <= 1'b1;
          u_we_o   <= 1'b1;
          u_adr_o  <= UART_BASE;
          u_dat_o  <= {24'h0, mem_dat[7:0]};
          state    <= SEND;
        end
        SEND: if (u_ack_i) begin
          rem      <= rem - LEN_W'(1);
          byte_idx <= byte_idx + 2'd1;
          u_stb_o  <= 1'b0;
          u_we_o   <= 1'b0;
          u_adr_o  <= '0;
          state    <= GAP;
        end
        GAP: begin
          if (rem == '0) begin
            done  <= 1'b1;
            state <= FIN;
          end else if (byte_idx == 2'd0) begin
            mem_adr <= addr;
            mem_stb <= 1'b1;
            state   <= FETCH;
          end else begin
            u_stb_o <= 1'b1;
            u_we_o  <= 1'b1;
            u_adr_o <= UART_BASE;
            u_dat_o <= {24'h0, word[{byte_idx, 3'b000} +: 8]};
            state   <= SEND;
          end
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_dma.sv
// tb_uart_tx_dma: scoreboard bench driving directed transfers through memory and UART responders
module tb_uart_tx_dma;
  localparam logic [31:0] UB = 32'h40;
  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        cfg_start = 1'b0;
  logic [31:0] cfg_base = '0;
  logic [15:0] cfg_len = '0;
  logic        busy, done, err, mem_stb, u_we_o, u_stb_o;
  logic [31:0] mem_adr, u_adr_o, u_dat_o;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_dat = '0;
  logic        u_ack_i = 1'b0;
  int          nvec = 0;
  int          nmis = 0;
  logic [7:0]  exp_q [$];
  logic [31:0] exp_rd [$];
  logic [31:0] mem [int];
  int          lat = 0;
  int          rd_cnt = 0;
  int          done_cnt = 0;
  int          err_cnt = 0;
  logic        busy_seen = 1'b0;
  logic        exp_done_busy = 1'b1;
  int          stall_byte = 0;
  int          stall_len = 0;
  int          stall_cnt = 0;
  logic        stall_all = 1'b0;

  uart_tx_dma #(.UART_BASE(UB), .LEN_W(16)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .cfg_start(cfg_start), .cfg_base(cfg_base),
    .cfg_len(cfg_len), .busy(busy), .done(done), .err(err), .mem_adr(mem_adr), .mem_stb(mem_stb),
    .mem_ack(mem_ack), .mem_dat(mem_dat), .u_adr_o(u_adr_o), .u_dat_o(u_dat_o), .u_we_o(u_we_o),
    .u_stb_o(u_stb_o), .u_ack_i(u_ack_i)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // memory responder: acks after lat waiting cycles and checks the request address
  initial begin
    int wcnt;
    logic [31:0] held;
    wcnt = 0;
    held = '0;
    forever begin
      @(negedge sys_clk);
      if (sys_rst_n && mem_stb) begin
        if (wcnt == 0) held = mem_adr;
        else check("mem_adr_hold", mem_adr, held);
        if (wcnt >= lat) begin
          mem_ack = 1'b1;
          mem_dat = mem.exists(int'(mem_adr)) ? mem[int'(mem_adr)] : 32'hDEAD_BEEF;
          rd_cnt++;
          if (exp_rd.size() == 0) check("mem_extra_read", mem_adr, 32'hFFFF_FFFF);
          else check("mem_read_adr", mem_adr, exp_rd.pop_front());
          wcnt = 0;
        end else begin
          mem_ack = 1'b0;
          wcnt++;
        end
      end else begin
        mem_ack = 1'b0;
        wcnt = 0;
      end
    end
  end

  // UART responder: ack level, optionally stalled on one byte value or entirely
  initial forever begin
    @(posedge sys_clk);
    #1;
    if (stall_all) u_ack_i = 1'b0;
    else if (u_stb_o && u_dat_o[7:0] == stall_byte[7:0] && stall_cnt < stall_len) begin
      u_ack_i = 1'b0;
      stall_cnt++;
    end else u_ack_i = 1'b1;
  end

  // monitor: pops expected bytes on accepted writes and checks handshake rules
  initial begin
    logic stb_prev, acc_prev, done_prev;
    logic [31:0] dat_prev;
    stb_prev = 0; acc_prev = 0; done_prev = 0; dat_prev = '0;
    forever begin
      @(negedge sys_clk);
      if (!sys_rst_n) begin
        stb_prev = 0; acc_prev = 0; done_prev = 0;
      end else begin
        if (mem_stb && u_stb_o) check("mem_uart_exclusive", 32'(u_stb_o), 32'(1'b0));
        if (u_stb_o) begin
          if (acc_prev) check("uart_gap", 32'(u_stb_o), 32'(1'b0));
          if (stb_prev && !acc_prev) check("uart_hold_dat", u_dat_o, dat_prev);
          if (u_ack_i) begin
            check("uart_adr", u_adr_o, UB);
            check("uart_we", 32'(u_we_o), 32'(1'b1));
            if (exp_q.size() == 0) check("uart_extra_byte", u_dat_o, 32'hFFFF_FFFF);
            else check("uart_byte", u_dat_o, {24'h0, exp_q.pop_front()});
          end
        end
        if (done_prev) check("busy_after_done", 32'(busy), 32'(1'b0));
        if (done) begin
          done_cnt++;
          check("busy_at_done", 32'(busy), 32'(exp_done_busy));
        end
        if (err) err_cnt++;
        if (busy) busy_seen = 1'b1;
        acc_prev = u_stb_o && u_ack_i;
        stb_prev = u_stb_o;
        dat_prev = u_dat_o;
        done_prev = done;
      end
    end
  end

  task automatic start(input logic [31:0] b, input logic [15:0] l);
    @(posedge sys_clk); #1;
    cfg_base = b; cfg_len = l; cfg_start = 1'b1;
    @(posedge sys_clk); #1;
    cfg_start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int d0);
    for (int i = 0; i < 400 && done_cnt == d0; i++) @(posedge sys_clk);
    repeat (4) @(posedge sys_clk);
    #1;
    check({name, "_done_pulses"}, done_cnt - d0, 1);
    check({name, "_bytes_left"}, exp_q.size(), 0);
    check({name, "_reads_left"}, exp_rd.size(), 0);
    check({name, "_busy_idle"}, 32'(busy), 32'(1'b0));
  endtask

  initial begin
    int d0, r0, e0;
    mem[32'h100] = 32'h4443_4241;
    mem[32'h104] = 32'h0000_0045;
    mem[32'h200] = 32'h0000_00A7;
    mem[32'h300] = 32'h6463_6261;
    mem[32'h304] = 32'h6867_6665;
    #23;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_mem_stb", 32'(mem_stb), 0);
    check("rst_mem_adr", mem_adr, 0);
    check("rst_u_stb", 32'(u_stb_o), 0);
    check("rst_u_we", 32'(u_we_o), 0);
    check("rst_u_adr", u_adr_o, 0);
    check("rst_u_dat", u_dat_o, 0);
    sys_rst_n = 1'b1;
    repeat (2) @(posedge sys_clk);
    // T1: five bytes over two words
    d0 = done_cnt; r0 = rd_cnt;
    exp_rd = '{32'h100, 32'h104};
    exp_q = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
    start(32'h100, 16'd5);
    check("t1_busy_after_start", 32'(busy), 1);
    wait_done("t1", d0);
    check("t1_reads", rd_cnt - r0, 2);
    // T2: 20-cycle stall on byte 0x42
    d0 = done_cnt; r0 = rd_cnt;
    stall_byte = 32'h42; stall_len = 20; stall_cnt = 0;
    exp_rd = '{32'h100, 32'h104};
    exp_q = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
    start(32'h100, 16'd5);
    wait_done("t2", d0);
    check("t2_reads", rd_cnt - r0, 2);
    stall_len = 0;
    // T3: zero length
    d0 = done_cnt; r0 = rd_cnt;
    exp_done_busy = 1'b0; busy_seen = 1'b0;
    start(32'h100, 16'd0);
    check("t3_done_now", 32'(done), 1);
    check("t3_busy", 32'(busy), 0);
    repeat (3) @(posedge sys_clk); #1;
    check("t3_done_count", done_cnt - d0, 1);
    check("t3_no_reads", rd_cnt - r0, 0);
    check("t3_busy_never", 32'(busy_seen), 0);
    exp_done_busy = 1'b1;
    // T4: misaligned base
    d0 = done_cnt; r0 = rd_cnt; e0 = err_cnt; busy_seen = 1'b0;
    start(32'h102, 16'd4);
    check("t4_err_now", 32'(err), 1);
    repeat (3) @(posedge sys_clk); #1;
    check("t4_err_count", err_cnt - e0, 1);
    check("t4_no_done", done_cnt - d0, 0);
    check("t4_no_reads", rd_cnt - r0, 0);
    check("t4_busy_never", 32'(busy_seen), 0);
    // T5: slow memory and a start pulse while busy
    d0 = done_cnt; r0 = rd_cnt; lat = 3;
    exp_rd = '{32'h300, 32'h304};
    exp_q = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68};
    start(32'h300, 16'd8);
    check("t5_mem_stb", 32'(mem_stb), 1);
    check("t5_mem_adr", mem_adr, 32'h300);
    start(32'h100, 16'd2);
    wait_done("t5", d0);
    check("t5_reads", rd_cnt - r0, 2);
    lat = 0;
    // T6: reset while a byte is pending
    d0 = done_cnt;
    stall_all = 1'b1;
    exp_rd = '{32'h100};
    start(32'h100, 16'd4);
    for (int i = 0; i < 50 && !u_stb_o; i++) begin @(posedge sys_clk); #1; end
    check("t6_in_send", 32'(u_stb_o), 1);
    #3 sys_rst_n = 1'b0;
    #1;
    check("t6_rst_u_stb", 32'(u_stb_o), 0);
    check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_mem_stb", 32'(mem_stb), 0);
    check("t6_rst_done", 32'(done), 0);
    stall_all = 1'b0;
    repeat (2) @(posedge sys_clk);
    #3 sys_rst_n = 1'b1;
    repeat (2) @(posedge sys_clk);
    check("t6_no_done", done_cnt - d0, 0);
    exp_rd = '{32'h200};
    exp_q = '{8'hA7};
    start(32'h200, 16'd1);
    wait_done("t6", d0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
